// File: rtl/clock_meas_defs.sv
// rtl/clock_meas_defs.sv - shared state encodings and default width for the clock measurement blocks
package clock_meas_defs;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/clock_period_meter_if.sv
// rtl/clock_period_meter_if.sv - measured signal and measurement results of the clock period meter
interface clock_period_meter_if #(
  parameter int WIDTH = clock_meas_defs::DEFAULT_WIDTH
);

  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             lost;

  modport master (output sig_in, input period, input high_time, input valid, input lost);
  modport slave  (input sig_in, output period, output high_time, output valid, output lost);

endinterface

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 3-flop synchronizer for an asynchronous level with rise/fall strobes
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may be metastable, so edges are judged one stage later
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - counts clk cycles per period and high time of a slow asynchronous signal
module clock_period_meter import clock_meas_defs::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  clock_period_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] w_period_nxt;
  logic [WIDTH-1:0] r_high_time;
  logic [WIDTH-1:0] w_high_time_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_lost;
  logic             w_lost_nxt;
  logic             w_rise;
  logic             w_fall;

  edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // a fall landing exactly on MAX must not wrap; saturation then fires next cycle
  assign w_cnt_inc = (r_cnt == MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi        <= w_hi_nxt;
      r_period    <= w_period_nxt;
      r_high_time <= w_high_time_nxt;
      r_valid     <= w_valid_nxt;
      r_lost      <= w_lost_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hi_nxt        = r_hi;
    w_period_nxt    = r_period;
    w_high_time_nxt = r_high_time;
    w_valid_nxt     = 1'b0;
    w_lost_nxt      = r_lost;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_cnt_nxt   = CNT_ONE;
          w_lost_nxt  = 1'b0;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_period_nxt    = r_cnt;
          w_high_time_nxt = r_hi;
          w_valid_nxt     = 1'b1;
          w_cnt_nxt       = CNT_ONE;
          w_lost_nxt      = 1'b0;
        end else if (w_fall) begin
          w_hi_nxt  = r_cnt;
          w_cnt_nxt = w_cnt_inc;
        end else if (r_cnt == MAX) begin
          w_lost_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high_time;
  assign bus.valid     = r_valid;
  assign bus.lost      = r_lost;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed vector bench for clock_period_meter at WIDTH 16 and 4
module tb_clock_period_meter;

  logic clk = 1'b0;
  logic rst16;
  logic rst4;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   v16_n   = 0;
  int   v4_n    = 0;
  int   p15_n   = 0;
  bit   lost16_seen = 1'b0;
  bit   lost4_seen  = 1'b0;

  clock_period_meter_if #(.WIDTH(16)) if16 ();
  clock_period_meter_if #(.WIDTH(4))  if4 ();

  clock_period_meter #(.WIDTH(16)) u16 (.clk(clk), .rst(rst16), .bus(if16));
  clock_period_meter #(.WIDTH(4))  u4  (.clk(clk), .rst(rst4),  .bus(if4));

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int n_valid;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (if16.valid) v16_n++;
    if (if4.valid) begin
      v4_n++;
      if (if4.period == 4'd15) p15_n++;
    end
    if (if16.lost) lost16_seen = 1'b1;
    if (if4.lost) lost4_seen = 1'b1;
  endtask

  task automatic wave16(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      if16.sig_in = 1'b1;
      repeat (hi) tick();
      if16.sig_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic wave4(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      if4.sig_in = 1'b1;
      repeat (hi) tick();
      if4.sig_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    int first_lost;

    vecs[0] = '{hi: 5,  lo: 5,  n_valid: 4, exp_period: 10, exp_high: 5};
    vecs[1] = '{hi: 3,  lo: 7,  n_valid: 4, exp_period: 10, exp_high: 3};
    vecs[2] = '{hi: 2,  lo: 2,  n_valid: 4, exp_period: 4,  exp_high: 2};
    vecs[3] = '{hi: 7,  lo: 4,  n_valid: 4, exp_period: 11, exp_high: 7};
    vecs[4] = '{hi: 20, lo: 13, n_valid: 4, exp_period: 33, exp_high: 20};

    rst16 = 1'b0;
    rst4  = 1'b0;
    if16.sig_in = 1'b0;
    if4.sig_in  = 1'b0;
    repeat (3) tick();
    check("rst16_period", if16.period, 0);
    check("rst16_high", if16.high_time, 0);
    check("rst16_valid", if16.valid, 0);
    check("rst16_lost", if16.lost, 0);
    check("rst4_period", if4.period, 0);
    check("rst4_high", if4.high_time, 0);
    check("rst4_valid", if4.valid, 0);
    check("rst4_lost", if4.lost, 0);
    rst16 = 1'b1;
    rst4  = 1'b1;
    repeat (3) tick();

    // latency: E0 samples the rise, rise visible after E1, valid after E2
    if16.sig_in = 1'b1;
    tick();
    check("lat_rise_after_e0", u16.w_rise, 0);
    tick();
    check("lat_rise_after_e1", u16.w_rise, 1);
    tick();
    check("lat_rise_after_e2", u16.w_rise, 0);
    check("lat_arm_no_valid", if16.valid, 0);
    repeat (2) tick();
    if16.sig_in = 1'b0;
    repeat (5) tick();
    if16.sig_in = 1'b1;
    tick();
    check("lat_valid_after_e0", if16.valid, 0);
    tick();
    check("lat_valid_after_e1", if16.valid, 0);
    tick();
    check("lat_valid_after_e2", if16.valid, 1);
    check("lat_period", if16.period, 10);
    check("lat_high", if16.high_time, 5);
    tick();
    check("lat_valid_one_cycle", if16.valid, 0);
    repeat (2) tick();
    if16.sig_in = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 5; i++) begin
      v16_n       = 0;
      lost16_seen = 1'b0;
      wave16(vecs[i].hi, vecs[i].lo, 4);
      check($sformatf("vec%0d_nvalid", i), v16_n, vecs[i].n_valid);
      check($sformatf("vec%0d_period", i), if16.period, vecs[i].exp_period);
      check($sformatf("vec%0d_high", i), if16.high_time, vecs[i].exp_high);
      check($sformatf("vec%0d_nolost", i), lost16_seen, 0);
    end

    // reset mid-measurement, released while sig_in is low
    wave16(5, 5, 2);
    tick();
    tick();
    rst16 = 1'b0;
    #1;
    check("mrst_period", if16.period, 0);
    check("mrst_high", if16.high_time, 0);
    check("mrst_valid", if16.valid, 0);
    check("mrst_lost", if16.lost, 0);
    repeat (3) tick();
    rst16 = 1'b1;
    repeat (2) tick();
    v16_n = 0;
    wave16(5, 5, 1);
    check("mrst_arm_no_valid", v16_n, 0);
    wave16(5, 5, 2);
    check("mrst_nvalid", v16_n, 2);
    check("mrst_period_after", if16.period, 10);
    check("mrst_high_after", if16.high_time, 5);

    check("w4_idle_no_lost", lost4_seen, 0);

    // loss of signal on WIDTH=4: one pulse then held low
    v4_n       = 0;
    first_lost = 0;
    if4.sig_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 4) if4.sig_in = 1'b0;
      tick();
      if (if4.lost && first_lost == 0) first_lost = k;
    end
    check("lost_delay", first_lost, 18);
    check("lost_no_valid", v4_n, 0);
    check("lost_period_kept", if4.period, 0);

    if4.sig_in = 1'b1;
    tick();
    tick();
    check("lost_held_until_rise", if4.lost, 1);
    tick();
    check("lost_clears_on_rise", if4.lost, 0);
    check("lost_rearm_no_valid", if4.valid, 0);
    tick();
    if4.sig_in = 1'b0;
    repeat (4) tick();
    v4_n = 0;
    wave4(4, 4, 2);
    check("relock_nvalid", v4_n, 2);
    check("relock_period", if4.period, 8);
    check("relock_high", if4.high_time, 4);

    // period exactly MAX: rise and saturation coincide
    v4_n       = 0;
    p15_n      = 0;
    lost4_seen = 1'b0;
    wave4(8, 7, 3);
    check("max_nvalid", v4_n, 3);
    check("max_n_period15", p15_n, 2);
    check("max_period", if4.period, 15);
    check("max_high", if4.high_time, 8);
    check("max_no_lost", lost4_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measuring end for the divided clocks produced by the clock divider. The block samples an asynchronous, slower periodic signal in the `clk` domain and counts `clk` cycles between its rising edges. It reports the period and the high time of each complete cycle, and flags loss of signal. It sits beside the divider/counter pair as a self-check and is also usable as a general frequency monitor.

## Interface
- `WIDTH`, default 16: width of the internal counter and of both measurement outputs; the saturation value is MAX = 2^WIDTH-1.
- `clk  in  1`: reference clock; all state is updated on its rising edge.
- `rst  in  1`: asynchronous reset, active-low (`rst`=0 resets immediately).
- `sig_in  in  1`: asynchronous signal under measurement.
- `period  out  WIDTH`: `clk` cycles from one `sig_in` rising edge to the next.
- `high_time  out  WIDTH`: `clk` cycles from a rising edge to the following falling edge.
- `valid  out  1`: one-cycle pulse; `period` and `high_time` were updated this cycle.
- `lost  out  1`: level; no rising edge was seen within MAX cycles.

## Operation
- Synchronizer: `s1`←`sig_in`, `s2`←`s1`, `s3`←`s2` on each edge.
- `rise` = `s2`&~`s3`; `fall` = ~`s2`&`s3`.
- State IDLE (the reset state):
  - `cnt` holds; `fall` is ignored.
  - `rise` → MEASURE, `cnt`←1.
  - No outputs change, except that `lost` clears on `rise`.
- State MEASURE, priority rise > fall > saturation > count:
  - `rise`: `period`←`cnt`, `high_time`←`hi`, `valid`←1, `cnt`←1, `lost`←0; stay in MEASURE.
  - `fall`: `hi`←`cnt`, `cnt`←`cnt`+1.
  - `cnt`==MAX with no `rise`: `lost`←1 → IDLE; `period` and `high_time` keep their last values.
  - Otherwise `cnt`←`cnt`+1.
- The first rising edge after reset or after IDLE only arms the block. The first `valid` comes at the second rising edge.
- A `rise` coinciding with `cnt`==MAX: the rise wins, `period`=MAX is reported as valid, and no `lost` is raised.
- `hi` is not cleared at a rise. A missing fall cannot occur, because each rise requires a preceding fall.
- Arithmetic is unsigned, WIDTH bits. `cnt` never wraps; it stops at MAX via the saturation rule.
- Input constraint: each `sig_in` phase must last ≥2 `clk` cycles. Shorter phases give undefined measurements but must not lock the FSM.

## Timing
- Reset values: `period`=0, `high_time`=0, `valid`=0, `lost`=0, `s1`..`s3`=0, `cnt`=0, `hi`=0, state IDLE.
- Latency:
  - Edge E0 first samples `sig_in`=1 into `s1`.
  - `rise` is true during the cycle after E1.
  - `valid` is high for exactly the cycle after E2.
- `period` and `high_time` update on the same edge as `valid` and hold until the next `valid`.
- Reset asserted mid-measurement: all state returns to reset values immediately. Measurement re-arms from IDLE after release; the first `valid` comes at the second post-reset rising edge.
- `lost` rises MAX cycles after the last counted rise (`cnt`=1 → MAX) and stays high until the next `rise` detected in IDLE.

## Structure
- Shared header/package `clock_meas_defs`:
  - state encodings IDLE=1'b0, MEASURE=1'b1;
  - the default WIDTH.
- One sub-module, `edge_sync`: 3-flop synchronizer with `rise`/`fall` outputs, async active-low reset. It is reusable by the counter blocks.
- Top level: FSM, `cnt`, `hi`, output registers.

## Test plan
- `sig_in` toggles every 5 `clk` cycles, WIDTH=16 → after arming, `valid` every 10 cycles with `period`=10 and `high_time`=5; `lost`=0 throughout.
- Asymmetric input, high 3 / low 7 cycles → `period`=10, `high_time`=3.
- WIDTH=4 (MAX=15), `sig_in` held low after one rise → `lost`=1 exactly 15 cycles after the arming rise; a later toggle of period 8 → `lost` clears on the first rise, with `valid`/`period`=8 on the second.
- WIDTH=4, period exactly 15 → `valid` with `period`=15 and `lost` never set (simultaneous rise/saturation).
- Reset pulsed low for 3 cycles mid-cycle during a period-10 toggle → outputs 0 immediately; no `valid` until the second rise after release, which then reports `period`=10.
- Directed latency check: first `sig_in` rise aligned to a known edge E0 → `rise` detected after E1, and `valid` for the second rise exactly 2 edges after its own sampling edge.
